buzzer_controller: RTL and testbench
====================================

Name: buzzer_controller

Overview:
- Upstream sound-control stage for the buzzer tone generator.
- Converts CPU-written buzzer control bits into a clean `buzzer_enabled` / `buzzer_frequency` pair plus an 8-level envelope (duty) value.
- Supports continuous tone, a hardware-timed one-shot burst (31.25 ms or 125 ms), and a decaying envelope with 62.5 ms or 125 ms steps.
- All timing is counted in 32768 Hz `clk_en` ticks; the outputs feed the tone generator directly.

Parameters:
- SHOT_SHORT_TICKS, 1024, one-shot length for width=0 (31.25 ms)
- SHOT_LONG_TICKS, 4096, one-shot length for width=1 (125 ms)
- ENV_STEP_FAST_TICKS, 2048, envelope step period for rate=0 (62.5 ms)
- ENV_STEP_SLOW_TICKS, 4096, envelope step period for rate=1 (125 ms)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- clk_en  in  1  32768 Hz tick, one clk wide
- buzzer_on  in  1  continuous tone request (level)
- frequency_in  in  3  tone select from CPU register
- one_shot_trigger  in  1  single-clk pulse, start burst
- one_shot_width  in  1  0 = short, 1 = long
- envelope_enable  in  1  envelope decay active
- envelope_rate  in  1  0 = fast, 1 = slow step
- envelope_reset  in  1  single-clk pulse, restart envelope at level 7
- buzzer_enabled  out  1  tone gate to generator
- buzzer_frequency  out  3  registered copy of frequency_in
- envelope_level  out  3  7 = full, 0 = minimum
- one_shot_busy  out  1  burst in progress

Behaviour:
- Reset (reset_n=0 at a clk edge): buzzer_enabled=0, buzzer_frequency=0, envelope_level=7, one_shot_busy=0. All counters and pending flags are cleared. Reset overrides every other input, including mid-burst.
- Timing: all state updates except pulse capture occur only on clk edges with clk_en=1.
- Pulse capture:
  - one_shot_trigger and envelope_reset set pending flags on any clk cycle.
  - Pending flags are consumed, and cleared, on the next clk_en tick.
- buzzer_frequency: loaded from frequency_in on every tick, so there is 1 tick of latency.
- One-shot FSM, states IDLE and SHOT:
  - IDLE -> SHOT on a tick with trigger pending and buzzer_on=0. The shot counter loads the selected length-1, with width sampled at that tick. one_shot_busy is set.
  - A trigger while in SHOT, or while buzzer_on=1, is discarded (the pending flag is still cleared).
  - In SHOT, each tick decrements the counter. On the tick where the counter is 0, go to IDLE and clear busy. The burst therefore lasts exactly N ticks.
  - buzzer_on rising during SHOT does not abort the counter.
- buzzer_enabled: registered on each tick as buzzer_on OR next-state==SHOT. It rises on the same tick busy rises.
- Envelope:
  - "Sounding" means next buzzer_enabled=1.
  - On the tick sounding starts (0->1), or on a tick with envelope_reset pending: level=7 and the step counter loads period-1.
  - While sounding with envelope_enable=1 and level>0: the step counter decrements each tick. At 0 it decrements level and reloads period-1. envelope_rate is sampled at each reload.
  - Level holds at 0; it does not wrap.
  - envelope_enable=0 or not sounding: level forced to 7 and the counter is held reloaded.
  - Same-tick priority: reset-pending beats step expiry; sounding-start beats everything except reset_n.
- Width: counters are 12 bits (max 4095), and all lengths must be ≤4096.

Decomposition:
- Shared package buzzer_pkg holds:
  - the four tick constants;
  - the one-shot state enum {IDLE, SHOT};
  - the 3-bit frequency type, shared with the tone generator;
  - the 3-bit envelope level type.
- One sub-module, envelope_generator: step counter plus level register, with inputs tick, sounding_start, sounding, enable, rate, reset_pending.

Test Plan:
- Reset mid-burst: trigger, width=1, then reset_n=0 after 100 ticks -> next edge enabled=0, busy=0, level=7; no resumption after reset_n=1.
- Short one-shot: trigger, width=0, buzzer_on=0 -> enabled and busy high for exactly 1024 ticks, then both 0; buzzer_frequency tracks frequency_in=5 after 1 tick.
- Retrigger and blocking: trigger again at tick 500 of a long shot -> burst still ends at tick 4096. Trigger with buzzer_on=1 -> busy stays 0.
- Fast envelope: buzzer_on=1, envelope_enable=1, rate=0 -> level 7,6,…,0 stepping every 2048 ticks, level 0 reached at tick 14336 and held through tick 20000.
- Envelope reset collision: envelope_reset pulse on the same tick as a step expiry at level 4 -> level=7 and the counter restarts at 2047.
- Pulse between ticks: trigger asserted 3 clk cycles after a tick with clk_en low -> busy rises on the following tick, not before.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared types and tick constants for the buzzer sound-control path.
// Latency: n/a (definitions only); no backpressure.
package buzzer_pkg;

    localparam int unsigned SHOT_SHORT_TICKS    = 1024;
    localparam int unsigned SHOT_LONG_TICKS     = 4096;
    localparam int unsigned ENV_STEP_FAST_TICKS = 2048;
    localparam int unsigned ENV_STEP_SLOW_TICKS = 4096;

    localparam int unsigned TICK_CNT_W = 12;

    typedef enum logic {
        IDLE = 1'b0,
        SHOT = 1'b1
    } shot_state_e;

    typedef logic [2:0]            freq_t;
    typedef logic [2:0]            env_level_t;
    typedef logic [TICK_CNT_W-1:0] tick_cnt_t;

    localparam env_level_t ENV_LEVEL_MAX = 3'd7;

    // Counters run from length-1 down to 0, so a length of 4096 still fits 12 bits.
    function automatic tick_cnt_t ticks_to_load(input int unsigned ticks);
        return tick_cnt_t'(ticks - 1);
    endfunction

endpackage

// File: rtl/buzzer_controller_if.sv
// CPU-control / tone-generator signal bundle for the buzzer controller.
// Latency: n/a (wiring only); no backpressure.
interface buzzer_controller_if;
    import buzzer_pkg::*;

    logic       buzzer_on;
    freq_t      frequency_in;
    logic       one_shot_trigger;
    logic       one_shot_width;
    logic       envelope_enable;
    logic       envelope_rate;
    logic       envelope_reset;

    logic       buzzer_enabled;
    freq_t      buzzer_frequency;
    env_level_t envelope_level;
    logic       one_shot_busy;

    modport master (
        output buzzer_on, frequency_in, one_shot_trigger, one_shot_width,
               envelope_enable, envelope_rate, envelope_reset,
        input  buzzer_enabled, buzzer_frequency, envelope_level, one_shot_busy
    );

    modport slave (
        input  buzzer_on, frequency_in, one_shot_trigger, one_shot_width,
               envelope_enable, envelope_rate, envelope_reset,
        output buzzer_enabled, buzzer_frequency, envelope_level, one_shot_busy
    );

endinterface

// File: rtl/buzzer_controller_envelope_generator.sv
// Envelope step counter and 8-level decay register, advanced on clk_en ticks.
// Latency: level updates on the tick edge; no backpressure.
module envelope_generator #(
    parameter int unsigned FAST_TICKS = buzzer_pkg::ENV_STEP_FAST_TICKS,
    parameter int unsigned SLOW_TICKS = buzzer_pkg::ENV_STEP_SLOW_TICKS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tick,
    input  logic                   sounding_start,
    input  logic                   sounding,
    input  logic                   enable,
    input  logic                   rate,
    input  logic                   reset_pending,
    output buzzer_pkg::env_level_t level
);
    import buzzer_pkg::*;

    localparam tick_cnt_t FAST_LOAD = ticks_to_load(FAST_TICKS);
    localparam tick_cnt_t SLOW_LOAD = ticks_to_load(SLOW_TICKS);

    env_level_t level_q, level_d;
    tick_cnt_t  step_cnt_q, step_cnt_d;
    tick_cnt_t  reload;

    assign reload = rate ? SLOW_LOAD : FAST_LOAD;

    always_comb begin
        level_d    = level_q;
        step_cnt_d = step_cnt_q;
        if (tick) begin
            // A restart (new sound or envelope_reset) outranks any step expiring on this tick.
            if (sounding_start || reset_pending) begin
                level_d    = ENV_LEVEL_MAX;
                step_cnt_d = reload;
            end else if (sounding && enable) begin
                if (level_q != '0) begin
                    if (step_cnt_q == '0) begin
                        level_d    = level_q - env_level_t'(1);
                        step_cnt_d = reload;
                    end else begin
                        step_cnt_d = step_cnt_q - tick_cnt_t'(1);
                    end
                end
            end else begin
                level_d    = ENV_LEVEL_MAX;
                step_cnt_d = reload;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q    <= ENV_LEVEL_MAX;
            step_cnt_q <= '0;
        end else begin
            level_q    <= level_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/buzzer_controller.sv
// Turns CPU buzzer control bits into tone gate, frequency, one-shot burst and envelope level.
// Latency: outputs update on the clk_en tick after inputs are seen; no backpressure.
module buzzer_controller #(
    parameter int unsigned SHOT_SHORT_TICKS    = buzzer_pkg::SHOT_SHORT_TICKS,
    parameter int unsigned SHOT_LONG_TICKS     = buzzer_pkg::SHOT_LONG_TICKS,
    parameter int unsigned ENV_STEP_FAST_TICKS = buzzer_pkg::ENV_STEP_FAST_TICKS,
    parameter int unsigned ENV_STEP_SLOW_TICKS = buzzer_pkg::ENV_STEP_SLOW_TICKS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_en,
    buzzer_controller_if.slave bus
);
    import buzzer_pkg::*;

    localparam tick_cnt_t SHORT_LOAD = ticks_to_load(SHOT_SHORT_TICKS);
    localparam tick_cnt_t LONG_LOAD  = ticks_to_load(SHOT_LONG_TICKS);

    shot_state_e state_q, state_d;
    tick_cnt_t   shot_cnt_q, shot_cnt_d;
    logic        trig_pend_q, trig_pend_d;
    logic        env_rst_pend_q, env_rst_pend_d;
    logic        enabled_q, enabled_d;
    freq_t       freq_q, freq_d;

    logic        trig_now;
    logic        env_rst_now;
    logic        sounding_start;

    // A pulse landing on the tick cycle itself is consumed by that tick.
    assign trig_now    = trig_pend_q | bus.one_shot_trigger;
    assign env_rst_now = env_rst_pend_q | bus.envelope_reset;

    always_comb begin
        state_d        = state_q;
        shot_cnt_d     = shot_cnt_q;
        enabled_d      = enabled_q;
        freq_d         = freq_q;
        trig_pend_d    = trig_now;
        env_rst_pend_d = env_rst_now;
        if (clk_en) begin
            trig_pend_d    = 1'b0;
            env_rst_pend_d = 1'b0;
            freq_d         = bus.frequency_in;
            case (state_q)
                IDLE: begin
                    if (trig_now && !bus.buzzer_on) begin
                        state_d    = SHOT;
                        shot_cnt_d = bus.one_shot_width ? LONG_LOAD : SHORT_LOAD;
                    end
                end
                SHOT: begin
                    if (shot_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        shot_cnt_d = shot_cnt_q - tick_cnt_t'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            enabled_d = bus.buzzer_on | (state_d == SHOT);
        end
    end

    assign sounding_start = clk_en & enabled_d & ~enabled_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            shot_cnt_q     <= '0;
            trig_pend_q    <= 1'b0;
            env_rst_pend_q <= 1'b0;
            enabled_q      <= 1'b0;
            freq_q         <= '0;
        end else begin
            state_q        <= state_d;
            shot_cnt_q     <= shot_cnt_d;
            trig_pend_q    <= trig_pend_d;
            env_rst_pend_q <= env_rst_pend_d;
            enabled_q      <= enabled_d;
            freq_q         <= freq_d;
        end
    end

    envelope_generator #(
        .FAST_TICKS (ENV_STEP_FAST_TICKS),
        .SLOW_TICKS (ENV_STEP_SLOW_TICKS)
    ) u_env (
        .clk            (clk),
        .reset_n        (reset_n),
        .tick           (clk_en),
        .sounding_start (sounding_start),
        .sounding       (enabled_d),
        .enable         (bus.envelope_enable),
        .rate           (bus.envelope_rate),
        .reset_pending  (env_rst_now),
        .level          (bus.envelope_level)
    );

    assign bus.buzzer_enabled   = enabled_q;
    assign bus.buzzer_frequency = freq_q;
    assign bus.one_shot_busy    = (state_q == SHOT);

endmodule

// File: tb/tb_buzzer_controller.sv
// Self-checking bench: tick-level reference model of the buzzer controller, directed scenarios then random traffic.
module tb_buzzer_controller;

    logic clk = 1'b0;
    logic reset_n;
    logic clk_en;

    buzzer_controller_if bif ();

    buzzer_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int busy_ticks = 0;

    // Reference model: burst as "ticks remaining", envelope as "ticks until next step".
    int m_en, m_freq, m_level, shot_left, env_wait;
    bit trig_p, envr_p;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int step_period(input bit rate);
        return rate ? 4096 : 2048;
    endfunction

    task automatic model_step();
        bit t, r, new_en, start;
        if (!reset_n) begin
            m_en = 0; m_freq = 0; m_level = 7; shot_left = 0; env_wait = 0;
            trig_p = 0; envr_p = 0;
        end else if (!clk_en) begin
            trig_p = trig_p | bif.one_shot_trigger;
            envr_p = envr_p | bif.envelope_reset;
        end else begin
            t = trig_p | bif.one_shot_trigger;
            r = envr_p | bif.envelope_reset;
            trig_p = 0; envr_p = 0;
            m_freq = int'(bif.frequency_in);
            if (shot_left > 0) shot_left--;
            else if (t && !bif.buzzer_on) shot_left = bif.one_shot_width ? 4096 : 1024;
            new_en = bif.buzzer_on || (shot_left > 0);
            start  = new_en && (m_en == 0);
            if (start || r) begin
                m_level = 7; env_wait = step_period(bif.envelope_rate);
            end else if (new_en && bif.envelope_enable) begin
                if (m_level > 0) begin
                    env_wait--;
                    if (env_wait == 0) begin
                        m_level--; env_wait = step_period(bif.envelope_rate);
                    end
                end
            end else begin
                m_level = 7; env_wait = step_period(bif.envelope_rate);
            end
            m_en = new_en ? 1 : 0;
        end
    endtask

    task automatic cyc(input bit ce);
        clk_en = ce;
        @(posedge clk);
        model_step();
        #1;
        check_eq("enabled", bif.buzzer_enabled, m_en);
        check_eq("freq", bif.buzzer_frequency, m_freq);
        check_eq("level", bif.envelope_level, m_level);
        check_eq("busy", bif.one_shot_busy, (shot_left > 0) ? 1 : 0);
        if (ce && bif.one_shot_busy) busy_ticks++;
        bif.one_shot_trigger = 1'b0;
        bif.envelope_reset   = 1'b0;
    endtask

    task automatic tick_r();
        while ($urandom_range(0, 7) == 0) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick_r();
    endtask

    initial begin
        reset_n = 1'b0; clk_en = 1'b0;
        bif.buzzer_on = 1'b0; bif.frequency_in = 3'd0;
        bif.one_shot_trigger = 1'b0; bif.one_shot_width = 1'b0;
        bif.envelope_enable = 1'b0; bif.envelope_rate = 1'b0; bif.envelope_reset = 1'b0;
        m_en = 0; m_freq = 0; m_level = 7; shot_left = 0; env_wait = 0; trig_p = 0; envr_p = 0;

        // Reset state
        cyc(1'b1); cyc(1'b0);
        check_eq("rst_enabled", bif.buzzer_enabled, 0);
        check_eq("rst_freq", bif.buzzer_frequency, 0);
        check_eq("rst_level", bif.envelope_level, 7);
        check_eq("rst_busy", bif.one_shot_busy, 0);
        reset_n = 1'b1;
        run_ticks(3);

        // Short one-shot, frequency latency
        bif.frequency_in = 3'd5; bif.one_shot_width = 1'b0; bif.one_shot_trigger = 1'b1;
        busy_ticks = 0;
        cyc(1'b1);
        check_eq("freq_lat", bif.buzzer_frequency, 5);
        check_eq("short_start", bif.one_shot_busy, 1);
        run_ticks(1100);
        check_eq("short_len", busy_ticks, 1024);

        // Long shot with retrigger at tick 500, then trigger blocked by buzzer_on
        bif.one_shot_width = 1'b1; bif.one_shot_trigger = 1'b1;
        busy_ticks = 0;
        cyc(1'b1);
        run_ticks(499);
        bif.one_shot_trigger = 1'b1;
        cyc(1'b1);
        run_ticks(3700);
        check_eq("long_len", busy_ticks, 4096);
        bif.buzzer_on = 1'b1; bif.one_shot_trigger = 1'b1;
        cyc(1'b1);
        check_eq("blocked_busy", bif.one_shot_busy, 0);
        run_ticks(10);
        bif.buzzer_on = 1'b0;
        run_ticks(5);

        // Fast envelope decay
        bif.envelope_enable = 1'b1; bif.envelope_rate = 1'b0;
        bif.buzzer_on = 1'b1;
        cyc(1'b1);
        check_eq("env_start", bif.envelope_level, 7);
        for (int j = 1; j <= 7; j++) begin
            run_ticks(2047);
            check_eq("env_hold", bif.envelope_level, 8 - j);
            run_ticks(1);
            check_eq("env_step", bif.envelope_level, 7 - j);
        end
        run_ticks(20000 - 14336);
        check_eq("env_floor", bif.envelope_level, 0);

        // Envelope reset colliding with the level-4 step expiry
        bif.buzzer_on = 1'b0;
        run_ticks(2);
        bif.buzzer_on = 1'b1;
        cyc(1'b1);
        run_ticks(8191);
        check_eq("coll_pre", bif.envelope_level, 4);
        bif.envelope_reset = 1'b1;
        cyc(1'b1);
        check_eq("coll_reset", bif.envelope_level, 7);
        run_ticks(2047);
        check_eq("coll_hold", bif.envelope_level, 7);
        run_ticks(1);
        check_eq("coll_step", bif.envelope_level, 6);

        // Trigger arriving between ticks
        bif.buzzer_on = 1'b0; bif.one_shot_width = 1'b0;
        run_ticks(3);
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        bif.one_shot_trigger = 1'b1;
        cyc(1'b0);
        check_eq("gap_busy0", bif.one_shot_busy, 0);
        cyc(1'b0);
        check_eq("gap_busy1", bif.one_shot_busy, 0);
        cyc(1'b1);
        check_eq("gap_busy_tick", bif.one_shot_busy, 1);
        run_ticks(1100);

        // Reset in the middle of a long burst
        bif.one_shot_width = 1'b1; bif.one_shot_trigger = 1'b1;
        cyc(1'b1);
        run_ticks(100);
        check_eq("mid_busy", bif.one_shot_busy, 1);
        reset_n = 1'b0;
        cyc(1'($urandom_range(0, 1)));
        check_eq("mid_rst_enabled", bif.buzzer_enabled, 0);
        check_eq("mid_rst_busy", bif.one_shot_busy, 0);
        check_eq("mid_rst_level", bif.envelope_level, 7);
        reset_n = 1'b1;
        busy_ticks = 0;
        run_ticks(200);
        check_eq("no_resume", busy_ticks, 0);

        // Random traffic
        bif.buzzer_on = 1'b1;
        for (int i = 0; i < 14000; i++) begin
            if ($urandom_range(0, 499) == 0) bif.buzzer_on = ~bif.buzzer_on;
            bif.frequency_in = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) bif.one_shot_trigger = 1'b1;
            bif.one_shot_width = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1999) == 0) bif.envelope_enable = ~bif.envelope_enable;
            if ($urandom_range(0, 49) == 0) bif.envelope_rate = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1499) == 0) bif.envelope_reset = 1'b1;
            reset_n = ($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1;
            cyc(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
